// File: rtl/track_scheduler_if.sv
// Handshake bundle between the frame sequencer (master) and the track scheduler (slave).
interface track_scheduler_if;
  logic [15:0] track_vec;
  logic        frame_tick;
  logic        fetch_ack;
  logic [3:0]  track_iter;
  logic        fetch_req;
  logic        frame_done;
  logic [4:0]  served_cnt;
  logic        timeout_err;
  logic        overrun;
  logic        busy;

  modport master (
    output track_vec, frame_tick, fetch_ack,
    input  track_iter, fetch_req, frame_done, served_cnt, timeout_err, overrun, busy
  );

  modport slave (
    input  track_vec, frame_tick, fetch_ack,
    output track_iter, fetch_req, frame_done, served_cnt, timeout_err, overrun, busy
  );
endinterface

// File: rtl/track_scheduler.sv
// Per-frame track sweep: snapshots the enabled-track mask on frame_tick, requests
// each enabled track from the sample fetcher in ascending order, drops tracks whose
// fetch is not acknowledged within TIMEOUT cycles, and reports the served count.
module track_scheduler #(
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            reset,
  track_scheduler_if.slave sif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  // Wait-counter value seen in the last cycle before a track is dropped.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [7:0]  wait_q, wait_d;
  logic [3:0]  track_iter_q, track_iter_d;
  logic        fetch_req_q, fetch_req_d;
  logic        frame_done_q, frame_done_d;
  logic [4:0]  served_cnt_q, served_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        overrun_q, overrun_d;
  logic        busy_q, busy_d;
  logic [15:0] rem_mask;

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    wait_d        = wait_q;
    track_iter_d  = track_iter_q;
    fetch_req_d   = fetch_req_q;
    frame_done_d  = 1'b0;
    served_cnt_d  = served_cnt_q;
    timeout_err_d = 1'b0;
    overrun_d     = 1'b0;
    // Mask with the current track retired; all lower bits are already clear.
    rem_mask      = mask_q & ~(16'd1 << track_iter_q);

    unique case (state_q)
      IDLE: begin
        fetch_req_d = 1'b0;
        if (sif.frame_tick) begin
          mask_d       = sif.track_vec;
          wait_d       = 8'd0;
          served_cnt_d = 5'd0;
          if (sif.track_vec == 16'd0) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d      = REQ;
            track_iter_d = lowest_idx(sif.track_vec);
            fetch_req_d  = 1'b1;
          end
        end
      end

      REQ: begin
        overrun_d = sif.frame_tick;
        // An ack in the expiry cycle takes priority over the drop.
        if (sif.fetch_ack || (wait_q == WAIT_LAST)) begin
          if (sif.fetch_ack) begin
            served_cnt_d = served_cnt_q + 5'd1;
          end else begin
            timeout_err_d = 1'b1;
          end
          mask_d = rem_mask;
          wait_d = 8'd0;
          if (rem_mask != 16'd0) begin
            track_iter_d = lowest_idx(rem_mask);
            fetch_req_d  = 1'b1;
          end else begin
            state_d      = DONE;
            fetch_req_d  = 1'b0;
            frame_done_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      DONE: begin
        overrun_d   = sif.frame_tick;
        fetch_req_d = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        state_d     = IDLE;
        fetch_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      mask_q        <= 16'd0;
      wait_q        <= 8'd0;
      track_iter_q  <= 4'd0;
      fetch_req_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      served_cnt_q  <= 5'd0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      wait_q        <= wait_d;
      track_iter_q  <= track_iter_d;
      fetch_req_q   <= fetch_req_d;
      frame_done_q  <= frame_done_d;
      served_cnt_q  <= served_cnt_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign sif.track_iter  = track_iter_q;
  assign sif.fetch_req   = fetch_req_q;
  assign sif.frame_done  = frame_done_q;
  assign sif.served_cnt  = served_cnt_q;
  assign sif.timeout_err = timeout_err_q;
  assign sif.overrun     = overrun_q;
  assign sif.busy        = busy_q;

endmodule

// File: tb/tb_track_scheduler.sv
// Bench for track_scheduler: table of frame scenarios plus hand-written reset sequences.
module tb_track_scheduler;

  localparam int TO = 4;

  logic clk;
  logic reset;
  track_scheduler_if sif ();

  track_scheduler #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame scenario: mask, tracks never acked, ack delay in request cycles,
  // sample index at which a stray frame_tick is injected (0 = none), expected results.
  typedef struct {
    logic [15:0] vec;
    logic [15:0] drop;
    int          dly;
    int          inj;
    int          exp_served;
    int          exp_to;
    int          exp_len;
  } vec_t;

  vec_t tbl[7];
  int   exp_q[$];
  int   checks;
  int   failures;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_iter"}, sif.track_iter, 0);
    chk({tag, "_req"}, sif.fetch_req, 0);
    chk({tag, "_done"}, sif.frame_done, 0);
    chk({tag, "_served"}, sif.served_cnt, 0);
    chk({tag, "_to"}, sif.timeout_err, 0);
    chk({tag, "_ovr"}, sif.overrun, 0);
    chk({tag, "_busy"}, sif.busy, 0);
  endtask

  // Runs one frame starting at the current negedge; all sampling on negedges.
  task automatic run_frame(input vec_t v);
    int k, req_cyc, to_seen, cur;
    bit acked, done;
    exp_q.delete();
    for (int i = 0; i < 16; i++) if (v.vec[i]) exp_q.push_back(i);
    sif.track_vec  = v.vec;
    sif.frame_tick = 1'b1;
    sif.fetch_ack  = 1'b0;
    @(negedge clk);
    sif.frame_tick = 1'b0;
    sif.track_vec  = ~v.vec;
    k = 1; req_cyc = 0; to_seen = 0; cur = -1; acked = 0; done = 0;
    while (!done && k < 300) begin
      sif.fetch_ack  = 1'b0;
      sif.frame_tick = 1'b0;
      chk("overrun", sif.overrun, (v.inj != 0 && k == v.inj + 1) ? 1 : 0);
      if (sif.timeout_err) begin
        to_seen++;
        req_cyc = 0;
      end
      if (acked) req_cyc = 0;
      acked = 0;
      if (sif.frame_done) begin
        chk("frame_len", k, v.exp_len);
        chk("served_cnt", sif.served_cnt, v.exp_served);
        chk("timeouts", to_seen, v.exp_to);
        chk("done_req", sif.fetch_req, 0);
        chk("tracks_left", exp_q.size(), 0);
        done = 1;
      end else begin
        chk("fetch_req", sif.fetch_req, 1);
        chk("busy", sif.busy, 1);
        if (req_cyc == 0) begin
          if (exp_q.size() == 0) chk("extra_track", sif.track_iter, -1);
          else cur = exp_q.pop_front();
        end
        chk("track_iter", sif.track_iter, cur);
        if (cur >= 0 && cur < 16 && !v.drop[cur] && req_cyc == v.dly) begin
          sif.fetch_ack = 1'b1;
          acked = 1;
        end
        req_cyc++;
      end
      if (v.inj != 0 && k == v.inj) sif.frame_tick = 1'b1;
      if (!done) begin
        @(negedge clk);
        k++;
      end
    end
    if (!done) chk("frame_done_seen", 0, 1);
    // Idle afterwards: served_cnt holds and a stray ack is ignored.
    sif.fetch_ack = 1'b1;
    @(negedge clk);
    sif.fetch_ack = 1'b0;
    chk("idle_done", sif.frame_done, 0);
    chk("idle_busy", sif.busy, 0);
    chk("idle_req", sif.fetch_req, 0);
    @(negedge clk);
    chk("served_hold", sif.served_cnt, v.exp_served);
    chk("ack_ignored_req", sif.fetch_req, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          vec       drop      dly inj srv to len
    tbl[0] = '{16'h8421, 16'h0000, 0, 0,  4, 0,  5};
    tbl[1] = '{16'h0000, 16'h0000, 0, 0,  0, 0,  1};
    tbl[2] = '{16'h0003, 16'h0001, 0, 0,  1, 1,  6};
    tbl[3] = '{16'hFFFF, 16'h0000, 2, 20, 16, 0, 49};
    tbl[4] = '{16'h0001, 16'h0001, 0, 0,  0, 1,  5};
    tbl[5] = '{16'h8000, 16'h0000, 3, 0,  1, 0,  5};
    tbl[6] = '{16'hA5A5, 16'h0100, 1, 0,  7, 1, 19};

    reset          = 1'b0;
    sif.track_vec  = 16'hFFFF;
    sif.frame_tick = 1'b0;
    sif.fetch_ack  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    sif.fetch_ack = 1'b0;
    reset = 1'b1;

    // First tick lands on the first edge after reset release.
    for (int t = 0; t < 7; t++) run_frame(tbl[t]);

    // Reset in REQ on track 3 with a coincident ack.
    sif.track_vec  = 16'h00F8;
    sif.frame_tick = 1'b1;
    @(negedge clk);
    sif.frame_tick = 1'b0;
    chk("rst_pre_iter", sif.track_iter, 3);
    chk("rst_pre_req", sif.fetch_req, 1);
    reset         = 1'b0;
    sif.fetch_ack = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    reset         = 1'b1;
    sif.fetch_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_done", sif.frame_done, 0);
      chk("post_rst_busy", sif.busy, 0);
    end
    run_frame('{16'h000F, 16'h0000, 1, 0, 4, 0, 9});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
